// File: rtl/uart_rx_core.sv
// uart_rx_core: UART receiver with mid-bit sampling and one-cycle result pulses.
// Default frame is 8N1; defining UART_RX_PARITY_EN switches to 8E1 with a parity-error pulse.
module uart_rx_core #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int UART_BAUD = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx_d,
    output logic [7:0] uart_rx_data,
    output logic       uart_rx_valid,
    output logic       uart_rx_busy,
    output logic       uart_rx_frame_err,
    output logic       uart_rx_par_err
);
    localparam logic [15:0] BAUD_CNT_MAX = 16'(CLK_FREQ / UART_BAUD);
    localparam logic [15:0] HALF_CNT     = BAUD_CNT_MAX / 16'd2;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

    state_t      state_q, state_d;
    logic [1:0]  rx_sync_q;
    logic        rx_prev_q;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        rx_s, start_edge, tick_full, tick_half;
`ifdef UART_RX_PARITY_EN
    logic        par_q, par_d;
    logic        perr_q, perr_d;
    logic        par_bad;
    assign par_bad         = ^{rx_shift_q, par_q};
    assign uart_rx_par_err = perr_q;
`else
    assign uart_rx_par_err = 1'b0;
`endif

    assign rx_s              = rx_sync_q[1];
    assign start_edge        = rx_prev_q & ~rx_s;
    assign tick_full         = baud_cnt_q == BAUD_CNT_MAX - 16'd1;
    assign tick_half         = baud_cnt_q == HALF_CNT - 16'd1;
    assign uart_rx_data      = data_q;
    assign uart_rx_valid     = valid_q;
    assign uart_rx_frame_err = ferr_q;
    assign uart_rx_busy      = state_q != IDLE;

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q + 16'd1;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d      = par_q;
        perr_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                state_d    = start_edge ? START : IDLE;
            end
            // a start bit that is high again at its midpoint was only a glitch
            START: if (tick_half) begin
                baud_cnt_d = '0;
                state_d    = rx_s ? IDLE : DATA;
            end
            DATA: if (tick_full) begin
                baud_cnt_d            = '0;
                rx_shift_d[bit_cnt_q] = rx_s;
                bit_cnt_d             = bit_cnt_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                state_d = (bit_cnt_q == 3'd7) ? PARITY : DATA;
`else
                state_d = (bit_cnt_q == 3'd7) ? STOP : DATA;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (tick_full) begin
                baud_cnt_d = '0;
                par_d      = rx_s;
                state_d    = STOP;
            end
`endif
            // returning to IDLE at mid-stop leaves half a bit to catch a back-to-back start edge
            STOP: if (tick_full) begin
                baud_cnt_d = '0;
                state_d    = rx_s ? IDLE : BREAK;
                ferr_d     = ~rx_s;
`ifdef UART_RX_PARITY_EN
                perr_d  = rx_s & par_bad;
                valid_d = rx_s & ~par_bad;
`else
                valid_d = rx_s;
`endif
                data_d = valid_d ? rx_shift_q : data_q;
            end
            BREAK: begin
                baud_cnt_d = '0;
                state_d    = rx_s ? IDLE : BREAK;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_sync_q  <= 2'b11;
            rx_prev_q  <= 1'b1;
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q      <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            rx_sync_q  <= {rx_sync_q[0], uart_rx_d};
            rx_prev_q  <= rx_sync_q[1];
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q      <= par_d;
            perr_q     <= perr_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: scoreboard bench for uart_rx_core; expected result pulses are queued as frames are sent.
module tb_uart_rx_core;
    localparam int BAUD = 434;
    localparam int HALF = BAUD / 2;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 2 + HALF + 10 * BAUD + 1;
`else
    localparam int LAT = 2 + HALF + 9 * BAUD + 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_d = 1'b1;
    logic [7:0] data;
    logic       valid, busy, ferr, perr;

    uart_rx_core dut (
        .clk(clk),
        .rst_n(rst_n),
        .uart_rx_d(rx_d),
        .uart_rx_data(data),
        .uart_rx_valid(valid),
        .uart_rx_busy(busy),
        .uart_rx_frame_err(ferr),
        .uart_rx_par_err(perr)
    );

    always #10 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_vec = 0;
    int          n_err = 0;
    logic [10:0] exp_q[$];
    logic [10:0] e;
    logic [7:0]  good = 8'h00;
    int unsigned fall_cyc = 0;
    int unsigned last_pulse_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {par_err, frame_err, valid} one-hot plus the data value the output must show
    always @(negedge clk) begin
        if ({perr, ferr, valid} != 3'b000) begin
            last_pulse_cyc = cyc;
            if (exp_q.size() == 0) chk("spurious", {29'd0, perr, ferr, valid}, 32'd0);
            else begin
                e = exp_q.pop_front();
                chk("kind", {29'd0, perr, ferr, valid}, {29'd0, e[10:8]});
                chk("data", {24'd0, data}, {24'd0, e[7:0]});
            end
        end
    end

    task automatic expect_frame(input logic [7:0] b, input logic stop, input logic par_flip);
        if (!stop) exp_q.push_back({3'b010, good});
`ifdef UART_RX_PARITY_EN
        else if (par_flip) exp_q.push_back({3'b100, good});
`endif
        else begin
            exp_q.push_back({3'b001, b});
            good = b;
        end
    endtask

    task automatic bit_out(input logic b, input int per);
        rx_d = b;
        repeat (per) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input int per, input logic par_flip);
        fall_cyc = cyc;
        bit_out(1'b0, per);
        for (int i = 0; i < 8; i++) bit_out(b[i], per);
`ifdef UART_RX_PARITY_EN
        bit_out(^b ^ par_flip, per);
`endif
        bit_out(stop, per);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 3 * BAUD) begin
            @(negedge clk);
            n++;
        end
        chk(tag, exp_q.size(), 32'd0);
    endtask

    initial begin
        #(20 * 200000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (5) @(negedge clk);
        chk("rst_data", {24'd0, data}, 32'd0);
        chk("rst_pulses", {29'd0, perr, ferr, valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        expect_frame(8'h55, 1'b1, 1'b0);
        fork
            send(8'h55, 1'b1, BAUD, 1'b0);
            begin
                repeat (5 * BAUD) @(negedge clk);
                chk("busy_mid", {31'd0, busy}, 32'd1);
            end
        join
        drain("drain_55");
        chk("latency", last_pulse_cyc - fall_cyc, LAT);
        chk("busy_after", {31'd0, busy}, 32'd0);
        repeat (20) @(negedge clk);

        rx_d = 1'b0;
        repeat (100) @(negedge clk);
        rx_d = 1'b1;
        repeat (50) @(negedge clk);
        chk("glitch_busy", {31'd0, busy}, 32'd1);
        repeat (150) @(negedge clk);
        chk("glitch_idle", {31'd0, busy}, 32'd0);
        repeat (20) @(negedge clk);

        expect_frame(8'hA3, 1'b0, 1'b0);
        send(8'hA3, 1'b0, BAUD, 1'b0);
        repeat (2000 - BAUD) @(negedge clk);
        drain("drain_ferr");
        chk("break_busy", {31'd0, busy}, 32'd1);
        rx_d = 1'b1;
        repeat (10) @(negedge clk);
        chk("break_exit", {31'd0, busy}, 32'd0);
        chk("ferr_keep", {24'd0, data}, 32'h55);
        repeat (20) @(negedge clk);

        foreach (exp_q[i]) chk("stale", 32'd1, 32'd0);
        expect_frame(8'h00, 1'b1, 1'b0);
        expect_frame(8'hFF, 1'b1, 1'b0);
        expect_frame(8'h81, 1'b1, 1'b0);
        send(8'h00, 1'b1, BAUD, 1'b0);
        send(8'hFF, 1'b1, BAUD, 1'b0);
        send(8'h81, 1'b1, BAUD, 1'b0);
        drain("drain_b2b");
        repeat (20) @(negedge clk);

        bit_out(1'b0, BAUD);
        for (int i = 0; i < 4; i++) bit_out(1'(8'h3C >> i), BAUD);
        rx_d = 1'b1;
        repeat (200) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        good = 8'h00;
        chk("abort_data", {24'd0, data}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        repeat (6 * BAUD) @(negedge clk);
        chk("abort_idle", {31'd0, busy}, 32'd0);
        expect_frame(8'h3C, 1'b1, 1'b0);
        send(8'h3C, 1'b1, BAUD, 1'b0);
        drain("drain_3c");
        repeat (20) @(negedge clk);

        expect_frame(8'h5A, 1'b1, 1'b0);
        send(8'h5A, 1'b1, 430, 1'b0);
        drain("drain_430");
        expect_frame(8'h5A, 1'b1, 1'b0);
        send(8'h5A, 1'b1, 438, 1'b0);
        drain("drain_438");
        repeat (20) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        expect_frame(8'h07, 1'b1, 1'b0);
        send(8'h07, 1'b1, BAUD, 1'b0);
        drain("drain_par_ok");
        expect_frame(8'h07, 1'b1, 1'b1);
        send(8'h07, 1'b1, BAUD, 1'b1);
        drain("drain_par_bad");
        repeat (20) @(negedge clk);
`endif

        chk("final_data", {24'd0, data}, {24'd0, good});
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
